// File: rtl/rc_pkg.sv
// Shared types and default constants for the RC step monitor.
// Holds the FSM state encoding and the real-to-fixed-point helper.
package rc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int FRAC_DEF = 12;
    localparam int FIX_ONE  = 1 << FRAC_DEF;

    // Round-to-nearest conversion of a real constant into Q.FRAC_DEF.
    function automatic int to_fix(input real r);
        return int'(r * real'(FIX_ONE));
    endfunction

    localparam int ALPHA_DEF   = to_fix(0.1);
    localparam int LIMIT_DEF   = to_fix(2.0);
    localparam int TOL_DEF     = to_fix(0.01);
    localparam int SETTLE_DEF  = 8;
    localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/rc_stage.sv
// One RC channel: first-order update with saturation, settle counter,
// sticky settled and violation flags.
// Ports: clk, rst (sync, active-high); clr clears flags/counter at run
// start; upd enables one update; target is the step value; v is the
// channel output; settled/violation are the sticky flags; settled_nxt is
// the value settled takes at the next edge.
module rc_stage #(
    parameter int W        = 18,
    parameter int FRAC     = 12,
    parameter int ALPHA    = 410,
    parameter int V_INIT   = 0,
    parameter int LIMIT    = 8192,
    parameter int TOL      = 41,
    parameter int SETTLE_N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                upd,
    input  logic signed [W-1:0] target,
    output logic signed [W-1:0] v,
    output logic                settled,
    output logic                settled_nxt,
    output logic                violation
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(SETTLE_N + 1) + 1;

    localparam logic signed [PW-1:0] V_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] V_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] ALPHA_X = PW'(ALPHA);
    localparam logic signed [PW-1:0] LIMIT_X = PW'(LIMIT);
    localparam logic signed [PW-1:0] TOL_X   = PW'(TOL);
    localparam logic [CW-1:0]        SET_C   = CW'(SETTLE_N);

    logic signed [W-1:0]  v_q, v_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 set_q, set_d;
    logic                 vio_q, vio_d;

    logic signed [PW-1:0] t_x, v_x, diff, prod, delta, sum, nxt_x, err;
    logic signed [W-1:0]  v_nxt;
    logic                 in_tol;

    always_comb begin
        t_x   = {{W{target[W-1]}}, target};
        v_x   = {{W{v_q[W-1]}}, v_q};
        diff  = t_x - v_x;
        prod  = diff * ALPHA_X;
        // Arithmetic shift floors toward minus infinity.
        delta = prod >>> FRAC;
        sum   = v_x + delta;
        if (sum > V_MAX) begin
            v_nxt = V_MAX[W-1:0];
        end else if (sum < V_MIN) begin
            v_nxt = V_MIN[W-1:0];
        end else begin
            v_nxt = sum[W-1:0];
        end
        nxt_x  = {{W{v_nxt[W-1]}}, v_nxt};
        err    = t_x - nxt_x;
        in_tol = (err <= TOL_X) && (err >= -TOL_X);
    end

    always_comb begin
        v_d   = v_q;
        cnt_d = cnt_q;
        set_d = set_q;
        vio_d = vio_q;
        if (clr) begin
            cnt_d = '0;
            set_d = 1'b0;
            vio_d = 1'b0;
        end else if (upd) begin
            v_d = v_nxt;
            if (!in_tol) begin
                cnt_d = '0;
            end else if (cnt_q < SET_C) begin
                cnt_d = cnt_q + 1'b1;
            end
            set_d = set_q | (cnt_d >= SET_C);
            vio_d = vio_q | (nxt_x >= LIMIT_X);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= W'(V_INIT);
            cnt_q <= '0;
            set_q <= 1'b0;
            vio_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            set_q <= set_d;
            vio_q <= vio_d;
        end
    end

    assign v           = v_q;
    assign settled     = set_q;
    assign settled_nxt = set_d;
    assign violation   = vio_q;

endmodule

// File: rtl/rc_step_monitor.sv
// Multi-channel RC step-response monitor: captures a step, runs the
// channels until all enabled ones settle or a cycle budget expires.
// Ports: clk, rst (sync, active-high), start, v_step, ch_en in;
// busy, done, settled, violation, timeout, v_out (channel i at [i*W +: W]).
module rc_step_monitor
    import rc_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int W        = 18,
    parameter int FRAC     = FRAC_DEF,
    parameter int ALPHA    = ALPHA_DEF,
    parameter int V_INIT   = 0,
    parameter int LIMIT    = LIMIT_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int SETTLE_N = SETTLE_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [W-1:0]   v_step,
    input  logic [N_CH-1:0]       ch_en,
    output logic                  busy,
    output logic                  done,
    output logic [N_CH-1:0]       settled,
    output logic [N_CH-1:0]       violation,
    output logic                  timeout,
    output logic [N_CH*W-1:0]     v_out
);

    localparam int YW = $clog2(TIMEOUT + 1) + 1;

    state_t              state_q, state_d;
    logic signed [W-1:0] tgt_q, tgt_d;
    logic [N_CH-1:0]     en_q, en_d;
    logic [YW-1:0]       cyc_q, cyc_d;
    logic                tout_q, tout_d;

    logic                clr;
    logic [N_CH-1:0]     upd;
    logic [N_CH-1:0]     set_nxt;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        en_d    = en_q;
        cyc_d   = cyc_q;
        tout_d  = tout_q;
        clr     = 1'b0;
        upd     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    tgt_d   = v_step;
                    en_d    = ch_en;
                    cyc_d   = '0;
                    tout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                upd   = en_q;
                cyc_d = cyc_q + 1'b1;
                // Settling is judged on this cycle's update, so it wins
                // over a budget that expires on the same cycle.
                if (&(set_nxt | ~en_q)) begin
                    state_d = S_DONE;
                end else if (cyc_d >= YW'(TIMEOUT)) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            en_q    <= '0;
            cyc_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            cyc_q   <= cyc_d;
            tout_q  <= tout_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rc_stage #(
            .W        (W),
            .FRAC     (FRAC),
            .ALPHA    (ALPHA),
            .V_INIT   (V_INIT),
            .LIMIT    (LIMIT),
            .TOL      (TOL),
            .SETTLE_N (SETTLE_N)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .clr         (clr),
            .upd         (upd[i]),
            .target      (tgt_q),
            .v           (v_out[i*W +: W]),
            .settled     (settled[i]),
            .settled_nxt (set_nxt[i]),
            .violation   (violation[i])
        );
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign timeout = tout_q;

endmodule

// File: tb/tb_rc_step_monitor.sv
// Randomized bench for rc_step_monitor against a behavioural RC model.
// Two instances: a settling configuration and a zero-tolerance one.
module tb_rc_step_monitor;

    localparam int W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start_a, start_b;
    logic signed [W-1:0] v_step;
    logic [1:0]          ch_en;

    logic         busy_a, done_a, timeout_a;
    logic [1:0]   settled_a, violation_a;
    logic [2*W-1:0] v_out_a;
    logic         busy_b, done_b, timeout_b;
    logic [1:0]   settled_b, violation_b;
    logic [2*W-1:0] v_out_b;

    rc_step_monitor #(
        .N_CH(2), .W(W), .FRAC(12), .ALPHA(2048), .V_INIT(0),
        .LIMIT(8192), .TOL(41), .SETTLE_N(8), .TIMEOUT(100)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .v_step(v_step),
        .ch_en(ch_en), .busy(busy_a), .done(done_a),
        .settled(settled_a), .violation(violation_a),
        .timeout(timeout_a), .v_out(v_out_a)
    );

    rc_step_monitor #(
        .N_CH(2), .W(W), .FRAC(12), .ALPHA(2048), .V_INIT(0),
        .LIMIT(8192), .TOL(0), .SETTLE_N(8), .TIMEOUT(20)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .v_step(v_step),
        .ch_en(ch_en), .busy(busy_b), .done(done_b),
        .settled(settled_b), .violation(violation_b),
        .timeout(timeout_b), .v_out(v_out_b)
    );

    int     n_chk = 0;
    int     n_err = 0;
    longint mv[2][2];
    longint obs_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint x);
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return x;
    endfunction

    function automatic longint vo(input int d, input int c);
        logic [2*W-1:0]      r;
        logic signed [W-1:0] s;
        r = (d != 0) ? v_out_b : v_out_a;
        s = r[c*W +: W];
        return longint'(s);
    endfunction

    function automatic logic [5:0] flags(input int d);
        // {busy, done, timeout, settled[1:0] -> packed below}
        if (d != 0) return {busy_b, done_b, timeout_b, 1'b0, settled_b};
        return {busy_a, done_a, timeout_a, 1'b0, settled_a};
    endfunction

    function automatic logic [1:0] vio(input int d);
        return (d != 0) ? violation_b : violation_a;
    endfunction

    task automatic do_run(input int d, input longint step, input logic [1:0] en,
                          input int tol, input int tmo, input bit poke,
                          output int n_upd);
        int     cnt[2];
        bit     sset[2];
        bit     svio[2];
        bit     fin, to;
        longint e;
        logic [5:0] f;
        string  p;
        p = $sformatf("d%0d_s%0d_e%0d", d, step, en);
        obs_q.delete();
        for (int ch = 0; ch < 2; ch++) begin
            cnt[ch] = 0; sset[ch] = 0; svio[ch] = 0;
        end
        v_step = W'(step);
        ch_en  = en;
        if (d != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        v_step = W'($urandom);
        ch_en  = 2'($urandom);
        f = flags(d);
        check({p, "_start_busy"}, f[5], 1);
        check({p, "_start_flags"}, {f[4:3], f[1:0], vio(d)}, 0);
        for (int ch = 0; ch < 2; ch++)
            check($sformatf("%s_start_v%0d", p, ch), vo(d, ch), mv[d][ch]);
        n_upd = 0;
        fin = 0;
        to = 0;
        for (int c = 1; c <= tmo && !fin; c++) begin
            if (flags(d) >> 5) n_upd++;
            for (int ch = 0; ch < 2; ch++) begin
                if (en[ch]) begin
                    mv[d][ch] = sat(mv[d][ch] + floor_div(2048 * (step - mv[d][ch]), 4096));
                    e = step - mv[d][ch];
                    if (e <= tol && e >= -tol) cnt[ch]++; else cnt[ch] = 0;
                    if (cnt[ch] >= 8) sset[ch] = 1;
                    if (mv[d][ch] >= 8192) svio[ch] = 1;
                end
            end
            fin = 1;
            for (int ch = 0; ch < 2; ch++)
                if (en[ch] && !sset[ch]) fin = 0;
            if (!fin && c == tmo) begin
                to = 1; fin = 1;
            end
            if (poke && c == 3) begin
                if (d != 0) start_b = 1'b1; else start_a = 1'b1;
                v_step = W'($urandom);
                ch_en  = 2'b11;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            for (int ch = 0; ch < 2; ch++)
                check($sformatf("%s_c%0d_v%0d", p, c, ch), vo(d, ch), mv[d][ch]);
            f = flags(d);
            check($sformatf("%s_c%0d_set", p, c), f[1:0], {sset[1], sset[0]});
            check($sformatf("%s_c%0d_vio", p, c), vio(d), {svio[1], svio[0]});
            obs_q.push_back(vo(d, 0));
            if (fin) begin
                check($sformatf("%s_c%0d_done", p, c), f[5:3], {2'b01, to});
            end else begin
                check($sformatf("%s_c%0d_run", p, c), f[5:4], 2'b10);
            end
        end
        @(posedge clk); #1;
        f = flags(d);
        check({p, "_idle"}, f[5:4], 2'b00);
        check({p, "_hold"}, {f[3], f[1:0], vio(d)},
              {to, sset[1], sset[0], svio[1], svio[0]});
    endtask

    initial begin
        int     nu;
        longint st;
        logic [1:0] en;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        v_step = '0; ch_en = '0;
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) mv[d][ch] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", {busy_a, done_a, timeout_a, settled_a, violation_a}, 0);
        check("rst_b", {busy_b, done_b, timeout_b, settled_b, violation_b}, 0);
        check("rst_va", v_out_a, 0);
        check("rst_vb", v_out_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_run(0, 4096, 2'b01, 41, 100, 0, nu);
        check("s1_v1", obs_q[0], 2048);
        check("s1_v2", obs_q[1], 3072);
        check("s1_v3", obs_q[2], 3584);
        check("s1_updates", nu, 14);
        check("s1_settled", settled_a, 2'b01);
        check("s1_vio", violation_a, 2'b00);

        do_run(0, 12288, 2'b01, 41, 100, 0, nu);
        check("s2_vio", violation_a[0], 1);

        do_run(1, 4096, 2'b01, 0, 20, 0, nu);
        check("s3_timeout", timeout_b, 1);
        check("s3_updates", nu, 20);
        check("s3_settled", settled_b, 2'b00);
        check("s3_stall", obs_q[19], 4095);

        do_run(0, -4096, 2'b10, 41, 100, 0, nu);
        check("s4_settled", settled_a, 2'b10);

        do_run(0, 700, 2'b00, 41, 100, 0, nu);
        check("s_noen_updates", nu, 1);
        check("s_noen_settled", settled_a, 2'b00);

        do_run(0, 30000, 2'b11, 41, 100, 1, nu);

        v_step = W'(5000); ch_en = 2'b11;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) mv[d][ch] = 0;
        check("s5_flags", {busy_a, done_a, timeout_a, settled_a, violation_a}, 0);
        check("s5_v", v_out_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("s5_nodone%0d", k), {busy_a, done_a}, 0);
        end

        for (int r = 0; r < 8; r++) begin
            st = longint'($urandom_range(40000)) - 20000;
            en = 2'($urandom);
            do_run(0, st, en, 41, 100, r[0], nu);
        end
        for (int r = 0; r < 3; r++) begin
            st = longint'($urandom_range(40000)) - 20000;
            en = 2'($urandom);
            do_run(1, st, en, 0, 20, 0, nu);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
